// File: rtl/gshare_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gshare_pkg
//  Purpose  : Shared types, constants and helper functions for the gshare
//             branch direction predictor (history width, 2-bit saturating
//             counter type, counter encodings, index hash, counter update).
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package gshare_pkg;

    // Width of the global history register and of the PC index.
    localparam int HIST_BITS = 7;

    // 2-bit saturating direction counter.
    typedef logic [1:0] ctr_t;

    // Counter encodings: the MSB alone gives the predicted direction.
    localparam ctr_t CTR_SNT = 2'd0;  // strongly not-taken
    localparam ctr_t CTR_WNT = 2'd1;  // weakly not-taken
    localparam ctr_t CTR_WT  = 2'd2;  // weakly taken
    localparam ctr_t CTR_ST  = 2'd3;  // strongly taken

    // Gshare hash: PC bits folded with global history by XOR. No carry, so
    // the result naturally stays within the table depth.
    function automatic logic [HIST_BITS-1:0] gshare_idx(
        input logic [HIST_BITS-1:0] pc,
        input logic [HIST_BITS-1:0] hist
    );
        return pc ^ hist;
    endfunction

    // Saturating step towards the observed outcome.
    function automatic ctr_t sat_update(
        input ctr_t ctr,
        input logic taken
    );
        ctr_t w_next;
        w_next = ctr;
        if (taken) begin
            if (ctr != CTR_ST) begin
                w_next = ctr + 2'd1;
            end
        end else begin
            if (ctr != CTR_SNT) begin
                w_next = ctr - 2'd1;
            end
        end
        return w_next;
    endfunction

endpackage : gshare_pkg
`default_nettype wire

// File: rtl/gshare_pht.sv
`default_nettype none
// ============================================================================
//  Module   : gshare_pht
//  Purpose  : Pattern history table for the gshare predictor. A flop array of
//             2-bit saturating counters with synchronous reset, one
//             combinational read port and one read-modify-write update port.
//  Ports    : clk        - clock, all updates on the rising edge
//             rst        - synchronous active-high reset (all entries to
//                          CTR_RESET)
//             i_rd_idx   - read index
//             o_rd_ctr   - counter at i_rd_idx (combinational, pre-update
//                          value when the same entry is being written)
//             i_wr_en    - apply a training update this edge
//             i_wr_idx   - entry to update
//             i_wr_taken - resolved outcome (increment when 1, else decrement)
//  Revision : 1.0 - initial release
// ============================================================================
module gshare_pht
    import gshare_pkg::*;
#(
    parameter int   HIST_BITS = gshare_pkg::HIST_BITS,
    parameter ctr_t CTR_RESET = CTR_WNT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [HIST_BITS-1:0] i_rd_idx,
    output ctr_t                 o_rd_ctr,
    input  logic                 i_wr_en,
    input  logic [HIST_BITS-1:0] i_wr_idx,
    input  logic                 i_wr_taken
);

    localparam int c_DEPTH = 2 ** HIST_BITS;

    ctr_t r_pht [c_DEPTH];

    // Reading the flops directly gives the pre-update value when a read and
    // a write hit the same entry in the same cycle.
    assign o_rd_ctr = r_pht[i_rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_pht[i] <= CTR_RESET;
            end
        end else if (i_wr_en) begin
            r_pht[i_wr_idx] <= sat_update(r_pht[i_wr_idx], i_wr_taken);
        end
    end

endmodule : gshare_pht
`default_nettype wire

// File: rtl/gshare_predictor.sv
`default_nettype none
// ============================================================================
//  Module   : gshare_predictor
//  Purpose  : Gshare conditional-branch direction predictor. Holds the global
//             history register (GHR) with its update priority and indexes a
//             pattern history table of 2-bit counters with PC XOR history.
//  Ports    : clk                - clock, all updates on the rising edge
//             areset             - synchronous active-high reset
//             predict_valid      - prediction consumed; shift GHR
//             predict_pc         - branch PC low bits to predict
//             predict_taken      - predicted direction (combinational)
//             predict_history    - current GHR, saved by the front end
//             train_valid        - a resolved branch is presented
//             train_taken        - actual outcome
//             train_mispredicted - branch mispredicted; roll GHR back
//             train_history      - GHR returned with the branch's prediction
//             train_pc           - PC of the resolved branch
//  Revision : 1.0 - initial release
// ============================================================================
module gshare_predictor
    import gshare_pkg::*;
#(
    parameter int   HIST_BITS = gshare_pkg::HIST_BITS,
    parameter ctr_t CTR_RESET = CTR_WNT
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic                 predict_valid,
    input  logic [HIST_BITS-1:0] predict_pc,
    output logic                 predict_taken,
    output logic [HIST_BITS-1:0] predict_history,
    input  logic                 train_valid,
    input  logic                 train_taken,
    input  logic                 train_mispredicted,
    input  logic [HIST_BITS-1:0] train_history,
    input  logic [HIST_BITS-1:0] train_pc
);

    logic [HIST_BITS-1:0] r_ghr;
    logic [HIST_BITS-1:0] w_pidx;
    logic [HIST_BITS-1:0] w_tidx;
    ctr_t                 w_pred_ctr;
    logic                 w_rollback;

    assign w_pidx = gshare_idx(predict_pc, r_ghr);
    assign w_tidx = gshare_idx(train_pc, train_history);

    gshare_pht #(
        .HIST_BITS (HIST_BITS),
        .CTR_RESET (CTR_RESET)
    ) u_pht (
        .clk        (clk),
        .rst        (areset),
        .i_rd_idx   (w_pidx),
        .o_rd_ctr   (w_pred_ctr),
        .i_wr_en    (train_valid),
        .i_wr_idx   (w_tidx),
        .i_wr_taken (train_taken)
    );

    // Counter MSB is the direction; no dependence on predict_valid.
    assign predict_taken   = w_pred_ctr[1];
    assign predict_history = r_ghr;

    // A mispredict rebuilds history from the snapshot taken at prediction
    // time plus the real outcome; it discards any speculative shift issued in
    // the same cycle, since that shift was made down the wrong path.
    assign w_rollback = train_valid && train_mispredicted;

    always_ff @(posedge clk) begin
        if (areset) begin
            r_ghr <= '0;
        end else if (w_rollback) begin
            r_ghr <= {train_history[HIST_BITS-2:0], train_taken};
        end else if (predict_valid) begin
            r_ghr <= {r_ghr[HIST_BITS-2:0], predict_taken};
        end
    end

endmodule : gshare_predictor
`default_nettype wire

// File: tb/tb_gshare_predictor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gshare_predictor
//  Purpose  : Self-checking bench for gshare_predictor. Stimulus pushes the
//             expected combinational outputs of each cycle into a queue; a
//             monitor pops and compares on the falling edge.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gshare_predictor;

    logic       clk = 1'b0;
    logic       areset;
    logic       predict_valid;
    logic [6:0] predict_pc;
    logic       predict_taken;
    logic [6:0] predict_history;
    logic       train_valid;
    logic       train_taken;
    logic       train_mispredicted;
    logic [6:0] train_history;
    logic [6:0] train_pc;

    gshare_predictor dut (
        .clk                (clk),
        .areset             (areset),
        .predict_valid      (predict_valid),
        .predict_pc         (predict_pc),
        .predict_taken      (predict_taken),
        .predict_history    (predict_history),
        .train_valid        (train_valid),
        .train_taken        (train_taken),
        .train_mispredicted (train_mispredicted),
        .train_history      (train_history),
        .train_pc           (train_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       taken;
        logic [6:0] hist;
    } exp_t;

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: counters as plain integers 0..3, history as integer.
    int m_pht [128];
    int m_ghr;

    // Monitor: compares DUT outputs against the oldest pending expectation.
    always @(negedge clk) begin
        if (q_exp.size() > 0) begin
            exp_t e;
            e = q_exp.pop_front();
            n_checks++;
            if (predict_taken === e.taken && predict_history === e.hist) begin
                n_pass++;
            end else begin
                $display("FAIL %s: taken=%b hist=%h, required taken=%b hist=%h",
                         e.name, predict_taken, predict_history, e.taken, e.hist);
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 128; i++) m_pht[i] = 1;
        m_ghr = 0;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        predict_valid = 1'b0; train_valid = 1'b0; train_mispredicted = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        areset = 1'b0;
    endtask

    // One clock cycle of stimulus. Called at posedge+1. When use_model is 0
    // the hand-derived constants et/eh are expected instead of the model.
    task automatic cycle(input bit pv, input int ppc,
                         input bit tv, input bit tt, input bit tm,
                         input int th, input int tpc,
                         input bit chk, input bit use_model,
                         input bit et, input int eh, input string nm);
        exp_t e;
        int   pidx, tidx, m_taken;
        predict_valid      = pv;
        predict_pc         = 7'(ppc);
        train_valid        = tv;
        train_taken        = tt;
        train_mispredicted = tm;
        train_history      = 7'(th);
        train_pc           = 7'(tpc);
        pidx    = (ppc ^ m_ghr) % 128;
        m_taken = (m_pht[pidx] >= 2) ? 1 : 0;
        if (chk) begin
            e.name  = nm;
            e.taken = use_model ? m_taken[0] : et;
            e.hist  = use_model ? 7'(m_ghr) : 7'(eh);
            q_exp.push_back(e);
        end
        @(posedge clk);
        if (tv && tm)   m_ghr = (th * 2 + (tt ? 1 : 0)) % 128;
        else if (pv)    m_ghr = (m_ghr * 2 + m_taken) % 128;
        if (tv) begin
            tidx = (tpc ^ th) % 128;
            if (tt) m_pht[tidx] = (m_pht[tidx] == 3) ? 3 : m_pht[tidx] + 1;
            else    m_pht[tidx] = (m_pht[tidx] == 0) ? 0 : m_pht[tidx] - 1;
        end
        #1;
    endtask

    initial begin
        int rpc, rhist, rtaken, rout;
        areset = 1'b1;
        predict_valid = 1'b0; predict_pc = '0;
        train_valid = 1'b0; train_taken = 1'b0; train_mispredicted = 1'b0;
        train_history = '0; train_pc = '0;
        model_reset();

        // Reset and basic prediction/training, hand-derived values.
        do_reset();
        cycle(0, 3, 0, 0, 0, 0, 0, 1, 0, 0, 7'h00, "reset");
        cycle(1, 3, 0, 0, 0, 0, 0, 1, 0, 0, 7'h00, "pred_pre");
        cycle(0, 3, 0, 0, 0, 0, 0, 1, 0, 0, 7'h00, "pred_post");
        cycle(0, 3, 1, 1, 0, 0, 3, 1, 0, 0, 7'h00, "train_same_cycle");
        cycle(0, 3, 0, 0, 0, 0, 0, 1, 0, 1, 7'h00, "train_after");
        // Load GHR=0011100 via rollback (history 0001110, not-taken).
        cycle(0, 3, 1, 0, 1, 7'h0E, 0, 1, 0, 1, 7'h00, "setup_ghr");
        // Rollback with a concurrent predict shift; rollback must win.
        cycle(1, 0, 1, 1, 1, 7'h55, 7'h10, 1, 0, 0, 7'h1C, "rb_pre");
        // 0x6E ^ 0x2B = 0x45 = 0x55 ^ 0x10, the entry just incremented.
        cycle(0, 7'h6E, 0, 0, 0, 0, 0, 1, 0, 1, 7'h2B, "rb_post");

        // Saturation at both ends.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(0, 5, 1, 1, 0, 0, 5, 0, 0, 0, 0, "");
        cycle(0, 5, 0, 0, 0, 0, 0, 1, 0, 1, 7'h00, "sat_hi");
        cycle(0, 5, 1, 0, 0, 0, 5, 1, 0, 1, 7'h00, "sat_pre_dec");
        cycle(0, 5, 0, 0, 0, 0, 0, 1, 0, 1, 7'h00, "sat_dec1");
        for (int i = 0; i < 7; i++) cycle(0, 5, 1, 0, 0, 0, 5, 0, 0, 0, 0, "");
        cycle(0, 5, 0, 0, 0, 0, 0, 1, 0, 0, 7'h00, "sat_lo");
        cycle(0, 5, 1, 1, 0, 0, 5, 0, 0, 0, 0, "");
        cycle(0, 5, 0, 0, 0, 0, 0, 1, 0, 0, 7'h00, "no_underflow");

        // Random predict-then-train against the reference model.
        do_reset();
        for (int it = 0; it < 500; it++) begin
            rpc   = int'($urandom_range(0, 127));
            rhist = m_ghr;
            rout  = (m_pht[(rpc ^ m_ghr) % 128] >= 2) ? 1 : 0;
            cycle(1, rpc, 0, 0, 0, 0, 0, 1, 1, 0, 0, "rand_pred");
            rtaken = int'($urandom_range(0, 1));
            cycle(bit'($urandom_range(0, 1)), int'($urandom_range(0, 127)),
                  1, rtaken[0], (rtaken != rout), rhist, rpc,
                  1, 1, 0, 0, "rand_train");
        end

        predict_valid = 1'b0; train_valid = 1'b0;
        repeat (3) @(posedge clk);
        if (q_exp.size() != 0) begin
            n_checks++;
            $display("FAIL drain: pending=%0d, required 0", q_exp.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_gshare_predictor
`default_nettype wire
